run_detector: RTL



---
 rtl/run_detector_pkg.sv | 18 +
 rtl/run_detector_sat_counter.sv | 27 ++
 rtl/run_detector.sv | 89 ++++++++
 3 files changed

// File: rtl/run_detector_pkg.sv
// Shared mode encodings and run-qualification rule for the run detector.
package run_det_pkg;

    localparam logic [1:0] MODE_ONES   = 2'b00;
    localparam logic [1:0] MODE_ZEROS  = 2'b01;
    localparam logic [1:0] MODE_EITHER = 2'b10;
    localparam logic [1:0] MODE_ALT    = 2'b11;

    // A full-length run only counts if its bit polarity suits the mode.
    function automatic logic qualify(input logic [1:0] m, input logic b);
        case (m)
            MODE_ONES:  return b;
            MODE_ZEROS: return !b;
            default:    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/run_detector_sat_counter.sv
// Saturating up-counter with synchronous clear and load; clr > load > inc.
module sat_counter #(
    parameter int             W   = 8,
    parameter logic [W-1:0]   MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/run_detector.sv
// Moore run-length detector: flags RUN_LEN qualifying samples in a row and
// counts detected runs in a saturating hit counter.
module run_detector
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = 4,
    parameter int HIT_W   = 8,
    parameter int CNT_W   = $clog2(RUN_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             w,
    input  logic [1:0]       mode,
    input  logic             clr_hits,
    output logic             z,
    output logic [CNT_W-1:0] run,
    output logic             last_w,
    output logic [HIT_W-1:0] hits
);

    logic [1:0] mode_q;
    logic       has_last;
    logic       mode_chg;
    logic       accept;
    logic       cont;
    logic       z_next;
    logic       hit_inc;

    assign mode_chg = (mode != mode_q);
    assign accept   = en && !mode_chg;
    assign cont     = has_last && ((mode_q == MODE_ALT) ? (w != last_w) : (w == last_w));

    assign z = (run == CNT_W'(RUN_LEN)) && qualify(mode_q, last_w);

    // Next-state z derived without a run_next copy: only a continuing sample
    // that lands run on RUN_LEN can hold or raise it.
    always_comb begin
        z_next = z;
        if (mode_chg) begin
            z_next = 1'b0;
        end else if (accept) begin
            z_next = cont && (run >= CNT_W'(RUN_LEN - 1)) && qualify(mode_q, w);
        end
    end

    assign hit_inc = z_next && !z;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_w   <= 1'b0;
            has_last <= 1'b0;
            mode_q   <= mode;
        end else if (mode_chg) begin
            mode_q   <= mode;
            has_last <= 1'b0;
        end else if (en) begin
            last_w   <= w;
            has_last <= 1'b1;
        end
    end

    sat_counter #(
        .W   (CNT_W),
        .MAX (CNT_W'(RUN_LEN))
    ) u_run (
        .clk      (clk),
        .reset    (reset),
        .inc      (accept && cont),
        .load     (accept && !cont),
        .load_val (CNT_W'(1)),
        .clr      (mode_chg),
        .count    (run)
    );

    sat_counter #(
        .W   (HIT_W),
        .MAX ({HIT_W{1'b1}})
    ) u_hits (
        .clk      (clk),
        .reset    (reset),
        .inc      (hit_inc),
        .load     (1'b0),
        .load_val ({HIT_W{1'b0}}),
        .clr      (clr_hits),
        .count    (hits)
    );

endmodule
